// File: rtl/rom_download_router.sv
// Routes ioctl ROM download bytes to per-region SDRAM toggle-handshake write ports.
// Latency: a write request toggles one cycle after the ioctl_wr rising edge (or after the ack of a preceding flush).
// Backpressure: nwait is low while a write awaits its ack; bytes arriving then are dropped and flagged.
//
// Ports:
//   clk_sys, res_n_i             clock and asynchronous active-low reset (release synchronised internally)
//   ioctl_downl/wr/addr/dout     download stream: active flag, byte strobe, byte address, byte data
//   port_req/port_ack            per-region toggle request / toggle acknowledge
//   port_a/port_ds/port_d/port_we region-local word address, byte enables {hi,lo}, data, write enable
//   nwait                        low = host must stall
//   rom_loaded/core_reset        download-complete flag and registered core reset (active high)
//   status_reset/btn_reset_n     OSD reset (high) and button reset (low) folded into core_reset
//   err_overrun/err_timeout      sticky error flags
module rom_download_router #(
  parameter int                            NUM_REGIONS = 2,
  parameter int                            ADDR_W      = 25,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {25'h20000, 25'h0},
  parameter bit                            WORD_MODE   = 1'b0,
  parameter int                            ACK_TIMEOUT = 255
) (
  input  logic                   clk_sys,
  input  logic                   res_n_i,
  input  logic                   ioctl_downl,
  input  logic                   ioctl_wr,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [NUM_REGIONS-1:0] port_ack,
  input  logic                   status_reset,
  input  logic                   btn_reset_n,
  output logic [NUM_REGIONS-1:0] port_req,
  output logic [ADDR_W-2:0]      port_a,
  output logic [1:0]             port_ds,
  output logic [15:0]            port_d,
  output logic                   port_we,
  output logic                   nwait,
  output logic                   rom_loaded,
  output logic                   core_reset,
  output logic                   err_overrun,
  output logic                   err_timeout
);

  localparam int                TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMO   = TMR_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_ACK, FLUSH} state_t;

  // Reset: asserts asynchronously, releases after two clk_sys edges.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_sys or negedge res_n_i) begin
    if (!res_n_i) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t                 state;
  logic                   wr_q;
  logic                   downl_q;
  logic                   wrote;        // at least one write issued in the current download
  logic [NUM_REGIONS-1:0] cur_oh;       // region of the write in flight / byte in HOLD
  logic [TMR_W-1:0]       tmr;

  // A byte that arrived in HOLD but could not pair; it is replayed once the
  // buffered byte's write has been acknowledged.
  logic                   pend_vld;
  logic [NUM_REGIONS-1:0] pend_oh;
  logic [ADDR_W-1:0]      pend_loc;
  logic [7:0]             pend_dat;

  // Region decode: bases ascend, so the last matching index is the highest.
  logic [NUM_REGIONS-1:0] sel_oh;
  logic [ADDR_W-1:0]      sel_base;
  logic                   in_range;
  logic [ADDR_W-1:0]      loc;

  always_comb begin
    sel_oh   = '0;
    sel_base = '0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (ioctl_addr >= REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_base  = REGION_BASE[i*ADDR_W +: ADDR_W];
        in_range  = 1'b1;
      end
    end
  end
  assign loc = ioctl_addr - sel_base;

  logic byte_edge;
  logic byte_vld;
  logic downl_rise;
  logic ack_ok;

  assign byte_edge  = ioctl_wr & ~wr_q;
  assign byte_vld   = byte_edge & in_range;
  assign downl_rise = ioctl_downl & ~downl_q;
  assign ack_ok     = ((port_ack ^ port_req) & cur_oh) == '0;

  // Byte to start on this cycle: a replayed pending byte takes precedence
  // over a live one, and is started straight off the ack so nwait stays low.
  logic                   use_pend;
  logic                   in_vld;
  logic [NUM_REGIONS-1:0] in_oh;
  logic [ADDR_W-1:0]      in_loc;
  logic [7:0]             in_dat;

  always_comb begin
    use_pend = pend_vld && ((state == IDLE) || (state == WAIT_ACK && ack_ok));
    in_vld   = use_pend || (state == IDLE && byte_vld);
    in_oh    = use_pend ? pend_oh  : sel_oh;
    in_loc   = use_pend ? pend_loc : loc;
    in_dat   = use_pend ? pend_dat : ioctl_dout;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      port_req    <= '0;
      port_a      <= '0;
      port_ds     <= '0;
      port_d      <= '0;
      rom_loaded  <= 1'b0;
      core_reset  <= 1'b1;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      wr_q        <= 1'b0;
      downl_q     <= 1'b0;
      wrote       <= 1'b0;
      cur_oh      <= '0;
      tmr         <= '0;
      pend_vld    <= 1'b0;
      pend_oh     <= '0;
      pend_loc    <= '0;
      pend_dat    <= '0;
    end else begin
      wr_q       <= ioctl_wr;
      downl_q    <= ioctl_downl;
      core_reset <= ~rom_loaded | status_reset | ~btn_reset_n;

      if (downl_rise) begin
        rom_loaded <= 1'b0;
        wrote      <= 1'b0;
      end else if (state == IDLE && !ioctl_downl && wrote && !pend_vld) begin
        rom_loaded <= 1'b1;
      end

      if (in_vld) begin
        if (use_pend) pend_vld <= 1'b0;
        cur_oh <= in_oh;
        port_a <= in_loc[ADDR_W-1:1];
        if (!WORD_MODE || in_loc[0]) begin
          port_d   <= {in_dat, in_dat};
          port_ds  <= {in_loc[0], ~in_loc[0]};
          port_req <= port_req ^ in_oh;
          tmr      <= '0;
          wrote    <= 1'b1;
          state    <= WAIT_ACK;
        end else begin
          port_d[7:0] <= in_dat;
          state       <= HOLD;
        end
      end else begin
        case (state)
          HOLD: begin
            // Level check also covers a download that ended while the
            // buffered byte was still a pending replay.
            if (!ioctl_downl) begin
              port_ds  <= 2'b01;
              port_req <= port_req ^ cur_oh;
              tmr      <= '0;
              wrote    <= 1'b1;
              state    <= FLUSH;
            end else if (byte_vld) begin
              if (loc[0] && sel_oh == cur_oh && loc[ADDR_W-1:1] == port_a) begin
                port_d[15:8] <= ioctl_dout;
                port_ds      <= 2'b11;
              end else begin
                port_ds  <= 2'b01;
                pend_vld <= 1'b1;
                pend_oh  <= sel_oh;
                pend_loc <= loc;
                pend_dat <= ioctl_dout;
              end
              port_req <= port_req ^ cur_oh;
              tmr      <= '0;
              wrote    <= 1'b1;
              state    <= WAIT_ACK;
            end
          end
          WAIT_ACK, FLUSH: begin
            if (ack_ok) begin
              state <= IDLE;
            end else if (tmr == TMO) begin
              // port_req is left as is; the SDRAM side may still complete it.
              err_timeout <= 1'b1;
              state       <= IDLE;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (byte_edge && (state == WAIT_ACK || state == FLUSH)) err_overrun <= 1'b1;
      if (byte_edge && state == IDLE && use_pend)               err_overrun <= 1'b1;
    end
  end

  assign port_we = rst_n & (ioctl_downl | (state != IDLE));
  assign nwait   = ~(state == WAIT_ACK || state == FLUSH);

endmodule
